// File: rtl/rhythm_hit_judge.sv
// rhythm_hit_judge
//   Per-lane timing judge for a rhythm game. Compares the 1-clk key press
//   pulse against the 1-clk "note at hit line" pulse on a millisecond time
//   base derived from i_Clk, grades each note PERFECT / GOOD / MISS, and
//   keeps score, current combo and best combo for the display stage.
//
// Ports
//   i_Clk       system clock
//   i_Rst       asynchronous reset, active-low
//   i_fPush     1-clk press pulse from the one-push key stage
//   i_fNote     1-clk pulse: note crosses the hit line
//   i_Clear     synchronous game restart, active-high, highest priority
//   o_fJudge    1-clk pulse: a new judgement is on o_Judge
//   o_Judge     last judgement, held: 00 none, 01 PERFECT, 10 GOOD, 11 MISS
//   o_Score     accumulated score, saturating
//   o_Combo     current combo, saturating, cleared by MISS
//   o_MaxCombo  best combo since reset/clear
module rhythm_hit_judge #(
  parameter int TICK_DIV    = 50_000,
  parameter int PERFECT_MS  = 30,
  parameter int GOOD_MS     = 80,
  parameter int PERFECT_PTS = 100,
  parameter int GOOD_PTS    = 50,
  parameter int SCORE_W     = 20,
  parameter int COMBO_W     = 10
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_fPush,
  input  logic               i_fNote,
  input  logic               i_Clear,
  output logic               o_fJudge,
  output logic [1:0]         o_Judge,
  output logic [SCORE_W-1:0] o_Score,
  output logic [COMBO_W-1:0] o_Combo,
  output logic [COMBO_W-1:0] o_MaxCombo
);

  localparam int DIV_W = $clog2(TICK_DIV + 1);
  localparam int AGE_W = $clog2(GOOD_MS + 1);

  localparam logic [DIV_W-1:0]   DIV_LAST    = DIV_W'(TICK_DIV - 1);
  localparam logic [AGE_W-1:0]   AGE_PERFECT = AGE_W'(PERFECT_MS);
  localparam logic [AGE_W-1:0]   AGE_GOOD    = AGE_W'(GOOD_MS);
  localparam logic [SCORE_W-1:0] PTS_PERFECT = SCORE_W'(PERFECT_PTS);
  localparam logic [SCORE_W-1:0] PTS_GOOD    = SCORE_W'(GOOD_PTS);

  localparam logic [1:0] J_NONE    = 2'b00;
  localparam logic [1:0] J_PERFECT = 2'b01;
  localparam logic [1:0] J_GOOD    = 2'b10;
  localparam logic [1:0] J_MISS    = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // waiting for a note; presses are remembered as "early"
    S_LATE = 2'd1,  // note has passed, waiting for a late press
    S_OUT  = 2'd2   // one-clock judgement output slot
  } state_t;

  state_t             state_r;
  logic [DIV_W-1:0]   div_cnt_r;
  logic               tick_r;
  logic               press_pend_r;
  logic [AGE_W-1:0]   press_age_r;
  logic [AGE_W-1:0]   late_age_r;
  logic               note_q_r;

  logic               fire_s;
  logic [1:0]         judge_s;
  logic [SCORE_W-1:0] pts_s;
  logic [COMBO_W-1:0] combo_next_s;

  function automatic logic [SCORE_W-1:0] score_sat_add(
    input logic [SCORE_W-1:0] a,
    input logic [SCORE_W-1:0] b
  );
    logic [SCORE_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[SCORE_W]) begin
      return '1;
    end else begin
      return sum[SCORE_W-1:0];
    end
  endfunction

  function automatic logic [COMBO_W-1:0] combo_sat_inc(input logic [COMBO_W-1:0] a);
    if (&a) begin
      return a;
    end else begin
      return a + COMBO_W'(1);
    end
  endfunction

  // Judgement decode: which event (if any) settles a note in this clock.
  always_comb begin
    fire_s  = 1'b0;
    judge_s = J_NONE;
    case (state_r)
      S_IDLE: begin
        if (i_fNote) begin
          // A push in the same clock is the newest press, age 0.
          if (i_fPush) begin
            fire_s  = 1'b1;
            judge_s = J_PERFECT;
          end else if (press_pend_r && (press_age_r <= AGE_PERFECT)) begin
            fire_s  = 1'b1;
            judge_s = J_PERFECT;
          end else if (press_pend_r && (press_age_r <= AGE_GOOD)) begin
            fire_s  = 1'b1;
            judge_s = J_GOOD;
          end else begin
            fire_s  = 1'b0;
            judge_s = J_NONE;
          end
        end else begin
          fire_s  = 1'b0;
          judge_s = J_NONE;
        end
      end
      S_LATE: begin
        // Push outranks both the expiry tick and a following note.
        if (i_fPush) begin
          fire_s  = 1'b1;
          judge_s = (late_age_r <= AGE_PERFECT) ? J_PERFECT : J_GOOD;
        end else if (i_fNote) begin
          fire_s  = 1'b1;
          judge_s = J_MISS;
        end else if (tick_r && (late_age_r == AGE_GOOD)) begin
          fire_s  = 1'b1;
          judge_s = J_MISS;
        end else begin
          fire_s  = 1'b0;
          judge_s = J_NONE;
        end
      end
      default: begin
        fire_s  = 1'b0;
        judge_s = J_NONE;
      end
    endcase
  end

  // Score increment and next combo for the decoded judgement.
  always_comb begin
    pts_s = '0;
    case (judge_s)
      J_PERFECT: pts_s = PTS_PERFECT;
      J_GOOD:    pts_s = PTS_GOOD;
      default:   pts_s = '0;
    endcase
    if (judge_s == J_MISS) begin
      combo_next_s = '0;
    end else begin
      combo_next_s = combo_sat_inc(o_Combo);
    end
  end

  // Tick divider, press tracking, FSM and registered outputs.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_r      <= S_IDLE;
      div_cnt_r    <= '0;
      tick_r       <= 1'b0;
      press_pend_r <= 1'b0;
      press_age_r  <= '0;
      late_age_r   <= '0;
      note_q_r     <= 1'b0;
      o_fJudge     <= 1'b0;
      o_Judge      <= J_NONE;
      o_Score      <= '0;
      o_Combo      <= '0;
      o_MaxCombo   <= '0;
    end else if (i_Clear) begin
      state_r      <= S_IDLE;
      div_cnt_r    <= '0;
      tick_r       <= 1'b0;
      press_pend_r <= 1'b0;
      press_age_r  <= '0;
      late_age_r   <= '0;
      note_q_r     <= 1'b0;
      o_fJudge     <= 1'b0;
      o_Judge      <= J_NONE;
      o_Score      <= '0;
      o_Combo      <= '0;
      o_MaxCombo   <= '0;
    end else begin
      if (div_cnt_r == DIV_LAST) begin
        div_cnt_r <= '0;
        tick_r    <= 1'b1;
      end else begin
        div_cnt_r <= div_cnt_r + DIV_W'(1);
        tick_r    <= 1'b0;
      end

      o_fJudge <= fire_s;
      if (fire_s) begin
        o_Judge <= judge_s;
        o_Score <= score_sat_add(o_Score, pts_s);
        o_Combo <= combo_next_s;
        if (combo_next_s > o_MaxCombo) begin
          o_MaxCombo <= combo_next_s;
        end
      end

      // Early-press memory: a note in S_IDLE always consumes it (used or
      // not); a newer press restarts the age; expired presses vanish quietly.
      if ((state_r == S_IDLE) && i_fNote) begin
        press_pend_r <= 1'b0;
        press_age_r  <= '0;
      end else if (i_fPush && (state_r != S_LATE)) begin
        press_pend_r <= 1'b1;
        press_age_r  <= '0;
      end else if (tick_r && press_pend_r) begin
        if (press_age_r >= AGE_GOOD) begin
          press_pend_r <= 1'b0;
          press_age_r  <= '0;
        end else begin
          press_age_r  <= press_age_r + AGE_W'(1);
        end
      end

      case (state_r)
        S_IDLE: begin
          if (fire_s) begin
            state_r <= S_OUT;
          end else if (i_fNote) begin
            state_r    <= S_LATE;
            late_age_r <= '0;
          end
        end
        S_LATE: begin
          if (fire_s) begin
            state_r <= S_OUT;
            // A note that arrives while the old one is being settled waits
            // in note_q and becomes the next late note.
            if (i_fNote) begin
              note_q_r <= 1'b1;
            end
          end else if (tick_r) begin
            late_age_r <= late_age_r + AGE_W'(1);
          end
        end
        S_OUT: begin
          if (note_q_r || i_fNote) begin
            note_q_r   <= 1'b0;
            state_r    <= S_LATE;
            late_age_r <= '0;
          end else begin
            state_r <= S_IDLE;
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rhythm_hit_judge.sv
// tb_rhythm_hit_judge
//   Directed scoreboard bench for rhythm_hit_judge with TICK_DIV=10.
//   Stimulus pushes the hand-computed judgement (code, score, combo, best
//   combo and the clock edge it must appear on) into a queue; a monitor pops
//   and compares on every o_fJudge pulse.
module tb_rhythm_hit_judge;

  localparam int TICK_DIV = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        push = 1'b0;
  logic        note = 1'b0;
  logic        clr = 1'b0;
  logic        fj;
  logic [1:0]  judge;
  logic [19:0] score;
  logic [9:0]  combo;
  logic [9:0]  maxc;

  int ecount = 0;
  int base   = 0;
  int tests  = 0;
  int fails  = 0;

  typedef struct {
    string      name;
    logic [1:0] j;
    int         score;
    int         combo;
    int         maxc;
    int         edge_n;
  } exp_t;

  exp_t q[$];

  rhythm_hit_judge #(.TICK_DIV(TICK_DIV)) dut (
    .i_Clk      (clk),
    .i_Rst      (rst_n),
    .i_fPush    (push),
    .i_fNote    (note),
    .i_Clear    (clr),
    .o_fJudge   (fj),
    .o_Judge    (judge),
    .o_Score    (score),
    .o_Combo    (combo),
    .o_MaxCombo (maxc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ecount <= ecount + 1;

  // Monitor: every judgement pulse must match the head of the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && fj) begin
        tests = tests + 1;
        if (q.size() == 0) begin
          fails = fails + 1;
          $display("FAIL unexpected_pulse: edge=%0d judge=%b score=%0d combo=%0d max=%0d, required no pulse",
                   ecount, judge, score, combo, maxc);
        end else begin
          e = q.pop_front();
          if (judge !== e.j || int'(score) != e.score || int'(combo) != e.combo ||
              int'(maxc) != e.maxc || ecount != e.edge_n) begin
            fails = fails + 1;
            $display("FAIL %s: judge=%b score=%0d combo=%0d max=%0d edge=%0d, required judge=%b score=%0d combo=%0d max=%0d edge=%0d",
                     e.name, judge, score, combo, maxc, ecount, e.j, e.score, e.combo, e.maxc, e.edge_n);
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present inputs for exactly the next rising edge.
  task automatic drive(input logic p, input logic n_);
    push = p;
    note = n_;
    @(negedge clk);
    push = 1'b0;
    note = 1'b0;
  endtask

  // Move so that the next edge lies one edge after a tick-sampling edge.
  task automatic align();
    while (((ecount + 1 - base) % TICK_DIV) != 2) @(negedge clk);
  endtask

  task automatic expect_next(input string nm, input logic [1:0] j, input int s,
                             input int c, input int m);
    exp_t e;
    e.name   = nm;
    e.j      = j;
    e.score  = s;
    e.combo  = c;
    e.maxc   = m;
    e.edge_n = ecount + 1;
    q.push_back(e);
  endtask

  task automatic drained(input string nm);
    idle(3);
    tests = tests + 1;
    if (q.size() != 0) begin
      fails = fails + 1;
      $display("FAIL %s: %0d expected judgements never appeared, required 0", nm, q.size());
      q.delete();
    end
  endtask

  task automatic check_zero(input string nm);
    tests = tests + 1;
    if (fj !== 1'b0 || judge !== 2'b00 || score !== 20'd0 || combo !== 10'd0 || maxc !== 10'd0) begin
      fails = fails + 1;
      $display("FAIL %s: fJudge=%b judge=%b score=%0d combo=%0d max=%0d, required all 0",
               nm, fj, judge, score, combo, maxc);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle(3);
    check_zero("reset_state");
    rst_n = 1'b1;
    base  = ecount;
    idle(5);
    check_zero("idle_after_reset");

    // Note, push 20 ticks later: PERFECT.
    align(); drive(1'b0, 1'b1); idle(199);
    expect_next("late_push_20", 2'b01, 100, 1, 1); drive(1'b1, 1'b0);
    drained("late_push_20_seen");

    // Push, note 50 ticks later: GOOD on the note edge.
    align(); drive(1'b1, 1'b0); idle(499);
    expect_next("early_push_50", 2'b10, 150, 2, 2); drive(1'b0, 1'b1);
    drained("early_push_50_seen");

    // Note alone: MISS on the 81st tick, best combo kept.
    align(); drive(1'b0, 1'b1); idle(808);
    expect_next("miss_tick81", 2'b11, 150, 0, 2); idle(1);
    drained("miss_tick81_seen");

    // Push and note in the same clock.
    align();
    expect_next("same_clk", 2'b01, 250, 1, 2); drive(1'b1, 1'b1);
    drained("same_clk_seen");

    // Push coincident with the expiry tick at LateAge 80: GOOD.
    align(); drive(1'b0, 1'b1); idle(808);
    expect_next("push_on_expiry", 2'b10, 300, 2, 2); drive(1'b1, 1'b0);
    drained("push_on_expiry_seen");

    // Late window edges: age 30 PERFECT, age 31 GOOD.
    align(); drive(1'b0, 1'b1); idle(299);
    expect_next("late_age_30", 2'b01, 400, 3, 3); drive(1'b1, 1'b0);
    drained("late_age_30_seen");
    align(); drive(1'b0, 1'b1); idle(309);
    expect_next("late_age_31", 2'b10, 450, 4, 4); drive(1'b1, 1'b0);
    drained("late_age_31_seen");

    // Second note 40 ticks in: MISS, then the queued note is PERFECT.
    align(); drive(1'b0, 1'b1); idle(399);
    expect_next("second_note_miss", 2'b11, 450, 0, 4); drive(1'b0, 1'b1); idle(99);
    expect_next("queued_note_perfect", 2'b01, 550, 1, 4); drive(1'b1, 1'b0);
    drained("queued_note_seen");

    // Stray push 100 ticks early expires silently; the note then MISSes.
    align(); drive(1'b1, 1'b0); idle(999); drive(1'b0, 1'b1); idle(808);
    expect_next("stray_then_miss", 2'b11, 550, 0, 4); idle(1);
    drained("stray_then_miss_seen");

    // Early press at exactly age 80 still GOOD.
    align(); drive(1'b1, 1'b0); idle(799);
    expect_next("early_age_80", 2'b10, 600, 1, 4); drive(1'b0, 1'b1);
    drained("early_age_80_seen");

    // Newer press restarts the age: 20 ticks, not 70.
    align(); drive(1'b1, 1'b0); idle(499); drive(1'b1, 1'b0); idle(199);
    expect_next("latest_press_wins", 2'b01, 700, 2, 4); drive(1'b0, 1'b1);
    drained("latest_press_seen");

    // Clear (with a coincident push) in the middle of S_LATE.
    align(); drive(1'b0, 1'b1); idle(199);
    clr = 1'b1; push = 1'b1;
    @(negedge clk);
    clr = 1'b0; push = 1'b0;
    base = ecount;
    check_zero("clear_mid_late");
    idle(900);
    drained("clear_no_miss");
    check_zero("after_clear_idle");

    // Async reset in the middle of S_LATE.
    align();
    expect_next("post_clear_perfect", 2'b01, 100, 1, 1); drive(1'b1, 1'b1);
    drained("post_clear_seen");
    drive(1'b0, 1'b1); idle(100);
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset_mid_late");
    idle(3);
    rst_n = 1'b1;
    base  = ecount;
    idle(900);
    drained("reset_no_miss");
    check_zero("after_reset_idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
